// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: opcode constants,
// the NOP encoding, the default address width and the fetch FSM encoding.
package instr_fetch_stage_pkg;

  localparam int ADDR_W = 32;

  // Opcodes the control unit decodes from instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b100011;

  // A bubble in IF/ID carries an all-zero instruction
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Fetch FSM encoding, kept as plain 2-bit constants for older tools
  typedef logic [1:0] fetchStateT;
  localparam fetchStateT ST_FETCH = 2'd0;
  localparam fetchStateT ST_DRAIN = 2'd1;
  localparam fetchStateT ST_HOLD  = 2'd2;

  // True for an opcode that redirects fetch from the ID stage
  function automatic logic isJumpOp(input logic [5:0] op);
    return op == OP_J;
  endfunction

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Reset and flush both produce a bubble
// (zero instruction, valid low); flush beats load, load beats hold.
module if_id_reg #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [31:0]       instrIn,
  input  logic [ADDR_W-1:0] pcPlus4In,
  output logic [31:0]       instrOut,
  output logic [ADDR_W-1:0] pcPlus4Out,
  output logic              validOut
);
  import instr_fetch_stage_pkg::*;

  logic [31:0]       instrReg;
  logic [ADDR_W-1:0] pcPlus4Reg;
  logic              validReg;

  // Register update: bubble on reset/flush, capture on load, otherwise hold
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instrReg   <= NOP_INSTR;
      pcPlus4Reg <= '0;
      validReg   <= 1'b0;
    end else if (load) begin
      instrReg   <= instrIn;
      pcPlus4Reg <= pcPlus4In;
      validReg   <= 1'b1;
    end
  end

  assign instrOut   = instrReg;
  assign pcPlus4Out = pcPlus4Reg;
  assign validOut   = validReg;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage with IF/ID register. Holds the PC, runs a
// ready-handshaked instruction memory port, applies branch/jump redirects
// (branch beats unstalled jump) and honours hazard stalls.
// Optional build macro IFETCH_PERF_CNT_EN adds FetchCount/BubbleCount.
module instr_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Jump,
  input  logic [25:0]       JumpIndex,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic              IMemReq,
  output logic [ADDR_W-1:0] IMemAddr,
  input  logic [31:0]       IMemRdata,
  input  logic              IMemReady,
  output logic [31:0]       InstrOut,
  output logic [ADDR_W-1:0] PCPlus4Out,
  output logic              ValidOut,
  output logic [5:0]        Op
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       FetchCount,
  output logic [31:0]       BubbleCount
`endif
);
  import instr_fetch_stage_pkg::*;

  fetchStateT        stateReg, stateNext;
  logic [ADDR_W-1:0] pcReg, pcNext;
  logic [ADDR_W-1:0] redirPcReg, redirPcNext;
  logic [31:0]       holdInstrReg, holdInstrNext;
  logic [ADDR_W-1:0] holdPcPlus4Reg, holdPcPlus4Next;
  logic              holdValidReg, holdValidNext;

  logic [ADDR_W-1:0] pcPlus4;
  logic [ADDR_W-1:0] branchTgt;
  logic [ADDR_W-1:0] jumpTgt;
  logic [ADDR_W-1:0] redirTgt;
  logic              jumpEff;
  logic              redirect;

  logic              ifLoad;
  logic              ifFlush;
  logic [31:0]       ifInstr;
  logic [ADDR_W-1:0] ifPcPlus4;

  // PC+4 wraps naturally at the address width
  assign pcPlus4   = pcReg + ADDR_W'(4);
  // Branch targets are word aligned regardless of what EX supplies
  assign branchTgt = BranchTarget & ~ADDR_W'(3);
  assign jumpTgt   = {PCPlus4Out[ADDR_W-1:28], JumpIndex, 2'b00};
  // A stalled jump is not taken; ID presents it again once it unstalls
  assign jumpEff   = Jump & ~Stall;
  assign redirect  = BranchTaken | jumpEff;
  assign redirTgt  = BranchTaken ? branchTgt : jumpTgt;

  // No request while reset is asserted or while a fetched word waits in HOLD
  assign IMemReq  = ~rst & (stateReg != ST_HOLD);
  assign IMemAddr = pcReg;

  // Next-state, PC and IF/ID control decisions for each FSM state
  always_comb begin
    stateNext       = stateReg;
    pcNext          = pcReg;
    redirPcNext     = redirPcReg;
    holdInstrNext   = holdInstrReg;
    holdPcPlus4Next = holdPcPlus4Reg;
    holdValidNext   = holdValidReg;
    ifLoad          = 1'b0;
    ifFlush         = 1'b0;
    ifInstr         = IMemRdata;
    ifPcPlus4       = pcPlus4;

    case (stateReg)
      ST_FETCH: begin
        if (IMemReady) begin
          if (redirect) begin
            // Returned word belongs to the wrong path
            pcNext  = redirTgt;
            ifFlush = 1'b1;
          end else if (Stall) begin
            // Park the word until decode can accept it
            holdInstrNext   = IMemRdata;
            holdPcPlus4Next = pcPlus4;
            holdValidNext   = 1'b1;
            stateNext       = ST_HOLD;
          end else begin
            ifLoad = 1'b1;
            pcNext = pcPlus4;
          end
        end else begin
          if (redirect) begin
            // Address must stay put until memory answers, so remember the target
            redirPcNext = redirTgt;
            ifFlush     = 1'b1;
            stateNext   = ST_DRAIN;
          end else if (!Stall) begin
            ifFlush = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (BranchTaken) begin
          redirPcNext = branchTgt;
        end
        if (IMemReady) begin
          pcNext    = BranchTaken ? branchTgt : redirPcReg;
          stateNext = ST_FETCH;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          holdValidNext = 1'b0;
          pcNext        = redirTgt;
          ifFlush       = 1'b1;
          stateNext     = ST_FETCH;
        end else if (!Stall && holdValidReg) begin
          ifLoad        = 1'b1;
          ifInstr       = holdInstrReg;
          ifPcPlus4     = holdPcPlus4Reg;
          holdValidNext = 1'b0;
          pcNext        = pcPlus4;
          stateNext     = ST_FETCH;
        end
      end

      default: begin
        stateNext = ST_FETCH;
      end
    endcase
  end

  // FSM, PC, pending redirect and hold buffer state
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg       <= ST_FETCH;
      pcReg          <= RESET_PC;
      redirPcReg     <= RESET_PC;
      holdInstrReg   <= NOP_INSTR;
      holdPcPlus4Reg <= '0;
      holdValidReg   <= 1'b0;
    end else begin
      stateReg       <= stateNext;
      pcReg          <= pcNext;
      redirPcReg     <= redirPcNext;
      holdInstrReg   <= holdInstrNext;
      holdPcPlus4Reg <= holdPcPlus4Next;
      holdValidReg   <= holdValidNext;
    end
  end

  if_id_reg #(
    .ADDR_W(ADDR_W)
  ) ifIdReg (
    .clk       (clk),
    .rst       (rst),
    .load      (ifLoad),
    .flush     (ifFlush),
    .instrIn   (ifInstr),
    .pcPlus4In (ifPcPlus4),
    .instrOut  (InstrOut),
    .pcPlus4Out(PCPlus4Out),
    .validOut  (ValidOut)
  );

  // Opcode goes straight to the control unit; a bubble decodes as opcode 0
  assign Op = InstrOut[31:26];

`ifdef IFETCH_PERF_CNT_EN
  // Index 0 counts instructions loaded into IF/ID, index 1 counts unstalled bubble cycles
  logic [1:0] perfInc;
  assign perfInc[0] = ifLoad;
  assign perfInc[1] = ~ValidOut & ~Stall;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gPerf
      logic [31:0] cntReg;
      // Free-running event counter, wraps at 2^32
      always_ff @(posedge clk) begin
        if (rst) begin
          cntReg <= '0;
        end else if (perfInc[gi]) begin
          cntReg <= cntReg + 32'd1;
        end
      end
    end
  endgenerate

  assign FetchCount  = gPerf[0].cntReg;
  assign BubbleCount = gPerf[1].cntReg;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios plus a randomized run
// checked against a stream-level model of the expected instruction order.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Stall = 1'b0;
  logic        Jump = 1'b0;
  logic [25:0] JumpIndex = '0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = '0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] IMemRdata;
  logic        IMemReady = 1'b0;
  logic [31:0] InstrOut;
  logic [31:0] PCPlus4Out;
  logic        ValidOut;
  logic [5:0]  Op;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] BubbleCount;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0020;
    if (a == 32'h4) return 32'h8C01_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign IMemRdata = memWord(IMemAddr);

  instr_fetch_stage #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Stall       (Stall),
    .Jump        (Jump),
    .JumpIndex   (JumpIndex),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemRdata   (IMemRdata),
    .IMemReady   (IMemReady),
    .InstrOut    (InstrOut),
    .PCPlus4Out  (PCPlus4Out),
    .ValidOut    (ValidOut),
    .Op          (Op)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .FetchCount  (FetchCount),
    .BubbleCount (BubbleCount)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input logic rdy);
    rst = 1'b1; Stall = 1'b0; Jump = 1'b0; BranchTaken = 1'b0;
    JumpIndex = '0; BranchTarget = '0; IMemReady = rdy;
    tick; tick;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    doReset(1'b1);
    rst = 1'b1; IMemReady = 1'b1;
    tick; tick;
    checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL rst_req got %b expected 0", IMemReq); end
    checks++; if (ValidOut !== 1'b0) begin errors++; $display("FAIL rst_valid got %b expected 0", ValidOut); end
    checks++; if (InstrOut !== 32'h0) begin errors++; $display("FAIL rst_instr got %h expected 0", InstrOut); end
    checks++; if (PCPlus4Out !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h expected 0", PCPlus4Out); end
    rst = 1'b0; #1;
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin errors++; $display("FAIL first_req got req=%b addr=%h expected req=1 addr=0", IMemReq, IMemAddr); end
    tick;
    checks++; if (ValidOut !== 1'b1 || InstrOut !== 32'h0000_0020 || Op !== 6'h00 || PCPlus4Out !== 32'h4) begin errors++; $display("FAIL first_instr got v=%b i=%h op=%h pc4=%h expected v=1 i=00000020 op=00 pc4=4", ValidOut, InstrOut, Op, PCPlus4Out); end
    checks++; if (IMemAddr !== 32'h4) begin errors++; $display("FAIL second_addr got %h expected 4", IMemAddr); end
    tick;
    checks++; if (ValidOut !== 1'b1 || InstrOut !== 32'h8C01_0004 || Op !== 6'h23 || PCPlus4Out !== 32'h8) begin errors++; $display("FAIL second_instr got v=%b i=%h op=%h pc4=%h expected v=1 i=8c010004 op=23 pc4=8", ValidOut, InstrOut, Op, PCPlus4Out); end
    tick;
    // Reset arriving together with a ready response drops that response
    rst = 1'b1; IMemReady = 1'b1;
    tick;
    checks++; if (ValidOut !== 1'b0 || InstrOut !== 32'h0 || IMemReq !== 1'b0) begin errors++; $display("FAIL rst_mid got v=%b i=%h req=%b expected v=0 i=0 req=0", ValidOut, InstrOut, IMemReq); end
    rst = 1'b0; #1;
    checks++; if (IMemAddr !== 32'h0) begin errors++; $display("FAIL rst_mid_addr got %h expected 0", IMemAddr); end
    $display("test_reset done");
  endtask

  task automatic test_mem_wait;
    doReset(1'b0);
    IMemReady = 1'b1;
    tick; tick;
    IMemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h8 || ValidOut !== 1'b0) begin errors++; $display("FAIL wait_%0d got req=%b addr=%h v=%b expected req=1 addr=8 v=0", i, IMemReq, IMemAddr, ValidOut); end
    end
    IMemReady = 1'b1;
    tick;
    checks++; if (ValidOut !== 1'b1 || InstrOut !== memWord(32'h8) || PCPlus4Out !== 32'hC || IMemAddr !== 32'hC) begin errors++; $display("FAIL wait_done got v=%b i=%h pc4=%h addr=%h expected v=1 i=%h pc4=c addr=c", ValidOut, InstrOut, PCPlus4Out, IMemAddr, memWord(32'h8)); end
    $display("test_mem_wait done");
  endtask

  task automatic test_jump;
    doReset(1'b0);
    IMemReady = 1'b1;
    tick; tick; tick; tick;
    // Jump presented while stalled must not be taken
    Stall = 1'b1; Jump = 1'b1; JumpIndex = 26'h40; IMemReady = 1'b0;
    tick;
    checks++; if (IMemAddr !== 32'h10 || ValidOut !== 1'b1 || PCPlus4Out !== 32'h10) begin errors++; $display("FAIL jump_stalled got addr=%h v=%b pc4=%h expected addr=10 v=1 pc4=10", IMemAddr, ValidOut, PCPlus4Out); end
    Stall = 1'b0; IMemReady = 1'b1;
    tick;
    Jump = 1'b0;
    checks++; if (ValidOut !== 1'b0 || InstrOut !== 32'h0 || IMemAddr !== 32'h100) begin errors++; $display("FAIL jump_redirect got v=%b i=%h addr=%h expected v=0 i=0 addr=100", ValidOut, InstrOut, IMemAddr); end
    tick;
    checks++; if (ValidOut !== 1'b1 || InstrOut !== memWord(32'h100) || PCPlus4Out !== 32'h104) begin errors++; $display("FAIL jump_target got v=%b i=%h pc4=%h expected v=1 i=%h pc4=104", ValidOut, InstrOut, PCPlus4Out, memWord(32'h100)); end
    $display("test_jump done");
  endtask

  task automatic test_stall_hold;
    doReset(1'b0);
    IMemReady = 1'b1;
    tick; tick; tick;
    Stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++; if (IMemReq !== 1'b0 || ValidOut !== 1'b1 || PCPlus4Out !== 32'hC || InstrOut !== memWord(32'h8)) begin errors++; $display("FAIL hold_%0d got req=%b v=%b pc4=%h i=%h expected req=0 v=1 pc4=c i=%h", i, IMemReq, ValidOut, PCPlus4Out, InstrOut, memWord(32'h8)); end
    end
    Stall = 1'b0;
    tick;
    checks++; if (ValidOut !== 1'b1 || InstrOut !== memWord(32'hC) || PCPlus4Out !== 32'h10 || IMemAddr !== 32'h10 || IMemReq !== 1'b1) begin errors++; $display("FAIL hold_release got v=%b i=%h pc4=%h addr=%h req=%b expected v=1 i=%h pc4=10 addr=10 req=1", ValidOut, InstrOut, PCPlus4Out, IMemAddr, IMemReq, memWord(32'hC)); end
    $display("test_stall_hold done");
  endtask

  task automatic test_branch_drain;
    doReset(1'b0);
    BranchTaken = 1'b1; BranchTarget = 32'h40;
    tick;
    checks++; if (ValidOut !== 1'b0 || IMemAddr !== 32'h0 || IMemReq !== 1'b1) begin errors++; $display("FAIL drain_enter got v=%b addr=%h req=%b expected v=0 addr=0 req=1", ValidOut, IMemAddr, IMemReq); end
    BranchTarget = 32'h80;
    tick;
    BranchTaken = 1'b0;
    checks++; if (IMemAddr !== 32'h0) begin errors++; $display("FAIL drain_stable got %h expected 0", IMemAddr); end
    tick;
    IMemReady = 1'b1;
    tick;
    checks++; if (IMemAddr !== 32'h80 || ValidOut !== 1'b0) begin errors++; $display("FAIL drain_exit got addr=%h v=%b expected addr=80 v=0", IMemAddr, ValidOut); end
    tick;
    checks++; if (ValidOut !== 1'b1 || PCPlus4Out !== 32'h84 || InstrOut !== memWord(32'h80)) begin errors++; $display("FAIL drain_target got v=%b pc4=%h i=%h expected v=1 pc4=84 i=%h", ValidOut, PCPlus4Out, InstrOut, memWord(32'h80)); end
    $display("test_branch_drain done");
  endtask

  task automatic test_priority_wrap;
    doReset(1'b0);
    IMemReady = 1'b1;
    tick; tick;
    BranchTaken = 1'b1; BranchTarget = 32'h203; Jump = 1'b1; JumpIndex = 26'h123; Stall = 1'b1;
    tick;
    BranchTaken = 1'b0; Jump = 1'b0; Stall = 1'b0;
    checks++; if (ValidOut !== 1'b0 || InstrOut !== 32'h0 || Op !== 6'h0 || IMemAddr !== 32'h200) begin errors++; $display("FAIL prio got v=%b i=%h op=%h addr=%h expected v=0 i=0 op=0 addr=200", ValidOut, InstrOut, Op, IMemAddr); end
    tick;
    checks++; if (ValidOut !== 1'b1 || PCPlus4Out !== 32'h204) begin errors++; $display("FAIL prio_target got v=%b pc4=%h expected v=1 pc4=204", ValidOut, PCPlus4Out); end
    BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    tick;
    BranchTaken = 1'b0;
    checks++; if (IMemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h expected fffffffc", IMemAddr); end
    tick;
    checks++; if (ValidOut !== 1'b1 || PCPlus4Out !== 32'h0 || InstrOut !== memWord(32'hFFFF_FFFC) || IMemAddr !== 32'h0) begin errors++; $display("FAIL wrap got v=%b pc4=%h i=%h addr=%h expected v=1 pc4=0 i=%h addr=0", ValidOut, PCPlus4Out, InstrOut, IMemAddr, memWord(32'hFFFF_FFFC)); end
    $display("test_priority_wrap done");
  endtask

  // Model: the IF/ID stream must deliver consecutive words from the current
  // path start, restart at each branch target with a bubble, and freeze on stall.
  task automatic test_random;
    logic [31:0] expPc;
    int          deliveries;
    int          bubbleExp;
    logic        pStall, pBranch, pReq, pReady, pValid;
    logic [31:0] pTarget, pAddr, pInstr, pPc4;
    doReset(1'b0);
    expPc = 32'h0; deliveries = 0; bubbleExp = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      Stall        = ($urandom_range(0, 3) == 0);
      IMemReady    = ($urandom_range(0, 4) < 3);
      BranchTaken  = ($urandom_range(0, 11) == 0);
      BranchTarget = $urandom & 32'h0000_03FF;
      if ($urandom_range(0, 9) == 0) BranchTarget = 32'hFFFF_FFF8 | ($urandom & 32'h7);
      if (!ValidOut && !Stall) bubbleExp++;
      pStall = Stall; pBranch = BranchTaken; pTarget = BranchTarget;
      pReq = IMemReq; pReady = IMemReady; pAddr = IMemAddr;
      pValid = ValidOut; pInstr = InstrOut; pPc4 = PCPlus4Out;
      tick;
      if (pReq && !pReady && IMemReq) begin
        checks++; if (IMemAddr !== pAddr) begin errors++; $display("FAIL rnd_addr_stable cyc=%0d got %h expected %h", cyc, IMemAddr, pAddr); end
      end
      if (pBranch) begin
        checks++; if (ValidOut !== 1'b0 || InstrOut !== 32'h0) begin errors++; $display("FAIL rnd_bubble cyc=%0d got v=%b i=%h expected v=0 i=0", cyc, ValidOut, InstrOut); end
        expPc = pTarget & 32'hFFFF_FFFC;
      end else if (pStall) begin
        checks++; if (ValidOut !== pValid || InstrOut !== pInstr || PCPlus4Out !== pPc4) begin errors++; $display("FAIL rnd_held cyc=%0d got v=%b i=%h pc4=%h expected v=%b i=%h pc4=%h", cyc, ValidOut, InstrOut, PCPlus4Out, pValid, pInstr, pPc4); end
      end else if (ValidOut) begin
        checks++; if (InstrOut !== memWord(expPc) || PCPlus4Out !== expPc + 32'd4) begin errors++; $display("FAIL rnd_deliver cyc=%0d got i=%h pc4=%h expected i=%h pc4=%h", cyc, InstrOut, PCPlus4Out, memWord(expPc), expPc + 32'd4); end
        $display("deliver pc=%h instr=%h", expPc, InstrOut);
        expPc = expPc + 32'd4;
        deliveries++;
      end else begin
        checks++; if (InstrOut !== 32'h0) begin errors++; $display("FAIL rnd_nop cyc=%0d got i=%h expected 0", cyc, InstrOut); end
      end
    end
    checks++; if (deliveries < 20) begin errors++; $display("FAIL rnd_progress got %0d deliveries expected at least 20", deliveries); end
`ifdef IFETCH_PERF_CNT_EN
    checks++; if (FetchCount !== 32'(deliveries)) begin errors++; $display("FAIL fetch_count got %0d expected %0d", FetchCount, deliveries); end
    checks++; if (BubbleCount !== 32'(bubbleExp)) begin errors++; $display("FAIL bubble_count got %0d expected %0d", BubbleCount, bubbleExp); end
`endif
    Stall = 1'b0; BranchTaken = 1'b0;
    $display("test_random done deliveries=%0d", deliveries);
  endtask

  initial begin
    test_reset;
    test_mem_wait;
    test_jump;
    test_stall_hold;
    test_branch_drain;
    test_priority_wrap;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

endmodule
